// File: rtl/iob_ram_be_rmw.sv
// Byte-enable adapter for a whole-word-write SRAM port: partial writes become
// an internal read-modify-write, reads and full writes pass straight through.
module iob_ram_be_rmw #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      rmw_cnt,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RD_CAP, MERGE, ACK} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   merge_d;
  logic                is_rd;
  logic                is_full;

  assign is_rd   = ~|wstrb;
  assign is_full = &wstrb;

  // RAM port A is driven straight from the state so C0 issues without delay.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = addr;
    ram_din  = wdata;
    for (int i = 0; i < int'(STRB_W); i++) begin
      merge_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_dout[8*i +: 8];
    end
    case (state_q)
      IDLE: begin
        if (valid) begin
          ram_en = 1'b1;
          ram_we = is_full ? '1 : '0;
        end
      end
      MERGE: begin
        ram_en   = 1'b1;
        ram_we   = '1;
        ram_addr = addr_q;
        ram_din  = merge_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            busy_q  <= 1'b1;
            if (is_rd) begin
              state_q <= RD_CAP;
            end else if (is_full) begin
              state_q <= ACK;
              ready_q <= 1'b1;
            end else begin
              state_q <= MERGE;
            end
          end
        end
        RD_CAP: begin
          rdata_q <= ram_dout;
          state_q <= ACK;
          ready_q <= 1'b1;
        end
        MERGE: begin
          // Saturating event counter: holds at all-ones instead of wrapping.
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          state_q <= ACK;
          ready_q <= 1'b1;
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign rmw_cnt = cnt_q;

endmodule

// File: tb/tb_iob_ram_be_rmw.sv
// Scoreboard bench for iob_ram_be_rmw: random and directed requests against a
// word-array reference model, with a read-first RAM model on port A.
module tb_iob_ram_be_rmw;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata, rdata_b, ram_din, ram_din_b, ram_dout;
  logic        ready, busy, ram_en, ready_b, busy_b, ram_en_b;
  logic [15:0] rmw_cnt;
  logic [1:0]  rmw_cnt_b;
  logic [3:0]  ram_we, ram_we_b;
  logic [8:0]  ram_addr, ram_addr_b;

  always #5 clk = ~clk;

  iob_ram_be_rmw #(.ADDR_W(9), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .busy(busy), .rmw_cnt(rmw_cnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout));

  // Same stimulus with a 2-bit counter to exercise saturation.
  iob_ram_be_rmw #(.ADDR_W(9), .DATA_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .rmw_cnt(rmw_cnt_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
    .ram_dout(ram_dout));

  // Read-first single-cycle RAM model behind port A.
  logic [31:0] ram_mem [0:511];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  typedef struct {
    logic [8:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
    logic [31:0] merged;
    logic [31:0] exp_rdata;
    logic [15:0] c16;
    logic [1:0]  c2;
  } item_t;

  item_t       q[$];
  logic [31:0] ref_mem [0:511];
  int          n_rmw = 0;
  logic [31:0] last_rd = 32'h0;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: apply one request to the word array and queue the expected response.
  task automatic model(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    item_t       it;
    logic [31:0] old;
    it.a = a; it.d = d; it.s = s; it.merged = 32'h0;
    old = ref_mem[a];
    if (s == 4'h0) begin
      it.lat = 2;
      last_rd = old;
    end else if (s == 4'hF) begin
      it.lat = 1;
      ref_mem[a] = d;
    end else begin
      it.lat = 2;
      for (int b = 0; b < 4; b++)
        it.merged[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
      ref_mem[a] = it.merged;
      n_rmw++;
    end
    it.exp_rdata = last_rd;
    it.c16 = 16'((n_rmw > 65535) ? 65535 : n_rmw);
    it.c2  = 2'((n_rmw > 3) ? 3 : n_rmw);
    q.push_back(it);
  endtask

  task automatic do_req(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit scr);
    bit got;
    model(a, d, s);
    @(posedge clk); #1;
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (scr) begin
        addr = 9'($urandom); wdata = $urandom; wstrb = 4'($urandom);
      end
      @(negedge clk);
      got = ready;
    end
    chk("ready_timeout", 32'(got), 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: binds each C0 to the oldest queued expectation and checks it through ACK.
  bit    active = 0;
  bit    prev_ready = 0;
  int    c0 = 0;
  item_t cur;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_ready) begin
        chk("gap_ready", 32'(ready), 32'd0);
        chk("gap_busy", 32'(busy), 32'd0);
      end
      if (active && cyc == c0 + 1 && cur.s != 4'h0 && cur.s != 4'hF) begin
        chk("merge_en_we", {27'h0, ram_en, ram_we}, 32'h1F);
        chk("merge_addr", 32'(ram_addr), 32'(cur.a));
        chk("merge_din", ram_din, cur.merged);
        chk("merge_din_b", ram_din_b, cur.merged);
      end
      if (active && cyc == c0 + 1 && cur.s == 4'h0) chk("rdcap_en", 32'(ram_en), 32'd0);
      if (active && cyc > c0) chk("busy", {30'h0, busy, busy_b}, 32'h3);
      if (rst) begin
        active = 0;
        prev_ready = 0;
      end else begin
        prev_ready = ready;
        if (ready) begin
          chk("ready_expected", 32'(active), 32'd1);
          if (active) begin
            chk("latency", 32'(cyc - c0), 32'(cur.lat));
            chk("rdata", rdata, cur.exp_rdata);
            chk("rdata_b", rdata_b, cur.exp_rdata);
            chk("rmw_cnt", 32'(rmw_cnt), 32'(cur.c16));
            chk("rmw_cnt_sat", 32'(rmw_cnt_b), 32'(cur.c2));
            chk("ready_b", 32'(ready_b), 32'd1);
            chk("ack_en", 32'(ram_en), 32'd0);
          end
          active = 0;
        end else if (!busy && valid) begin
          chk("overlap", 32'(active), 32'd0);
          chk("queue_nonempty", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            cur = q.pop_front();
            active = 1;
            c0 = cyc;
            chk("c0_en_we", {27'h0, ram_en, ram_we}, (cur.s == 4'hF) ? 32'h1F : 32'h10);
            chk("c0_en_we_b", {27'h0, ram_en_b, ram_we_b}, (cur.s == 4'hF) ? 32'h1F : 32'h10);
            chk("c0_addr", {7'h0, ram_addr, ram_addr_b}, {7'h0, cur.a, cur.a});
            if (cur.s == 4'hF) chk("c0_din", ram_din, cur.d);
          end
        end else if (!busy) begin
          chk("idle_en_we", {27'h0, ram_en, ram_we}, 32'h0);
        end
      end
    end
  end

  initial begin
    int          wr_seen, rdy_seen;
    logic [3:0]  s;
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready_busy", {30'h0, ready, busy}, 32'h0);
    chk("rst_cnt", 32'(rmw_cnt), 32'h0);
    chk("rst_ram", {27'h0, ram_en, ram_we}, 32'h0);
    mon_en = 1;

    // Directed: full write, read, partial write, read, valid held throughout.
    do_req(9'd5, 32'hDEADBEEF, 4'hF, 0);
    do_req(9'd5, 32'h0, 4'h0, 0);
    do_req(9'd5, 32'h00001122, 4'h3, 0);
    do_req(9'd5, 32'h0, 4'h0, 0);
    do_req(9'd0, 32'h0, 4'hF, 0);
    do_req(9'd0, 32'hAA000000, 4'h8, 0);
    do_req(9'd0, 32'h000000BB, 4'h1, 0);
    do_req(9'd0, 32'h0, 4'h0, 0);
    chk("addr0_final", ref_mem[0], 32'hAA0000BB);
    idle(2);

    // Reset asserted while in MERGE: the merged word still lands, then nothing else.
    do_req(9'd7, 32'h11223344, 4'hF, 0);
    model(9'd7, 32'h00005A00, 4'h2);
    @(posedge clk); #1;
    valid = 1'b1; addr = 9'd7; wdata = 32'h00005A00; wstrb = 4'h2;
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_rmw = 0;
    last_rd = 32'h0;
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_cnt", {14'h0, rmw_cnt, rmw_cnt_b}, 32'h0);
    chk("mid_rst_ready_busy", {30'h0, ready, busy}, 32'h0);
    wr_seen = 0; rdy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ram_en && ram_we != 4'h0) wr_seen++;
      if (ready) rdy_seen++;
    end
    chk("mid_rst_no_write", 32'(wr_seen), 32'd0);
    chk("mid_rst_no_ready", 32'(rdy_seen), 32'd0);
    do_req(9'd7, 32'h0, 4'h0, 0);

    // Five partial writes: the 2-bit counter must read 1,2,3,3,3.
    for (int i = 0; i < 5; i++) do_req(9'(10 + i), 32'h12345678, 4'h6, 0);
    idle(1);

    // Random mix with payload scrambling after C0 and random idle gaps.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: s = 4'h0;
        1: s = 4'hF;
        default: s = 4'($urandom_range(1, 14));
      endcase
      do_req(9'($urandom_range(0, 15)), $urandom, s, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("drain", 32'(q.size()) + 32'(active), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
